memory_arbiter: RTL and testbench

Shares the single RAM port between the instruction and data caches of every core. Each cycle in IDLE it selects one outstanding cache request and registers the owner. It drives the RAM from that owner's request until the RAM reports ACCESS, then releases the owner. It sits between the per-core icache/dcache blocks and the RAM model, behind the cache_control_if signals.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/memory_arbiter_rr_picker.sv | 33 +++
 rtl/memory_arbiter.sv | 134 +++++++++++++
 tb/tb_memory_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM status and memory arbiter state encodings.
// Pure declarations; no logic, no latency, no flow control.
package cpu_types_pkg;
    localparam int NUM_CPUS = 2;
    localparam int WORD_W   = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: first set request at or after i_start (wrapping), as one-hot and index.
// Purely combinational, zero latency; no flow control.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_first;
    logic [IW:0]   w_sum;

    // Rotate so that i_start lands at bit 0, then take the lowest set bit.
    assign w_rot = N'({i_req, i_req} >> i_start);
    assign o_any = |i_req;

    always_comb begin
        w_first = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_first = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, w_first} + {1'b0, i_start};
    assign o_idx = (w_sum >= N[IW:0]) ? IW'(w_sum - N[IW:0]) : w_sum[IW-1:0];
    assign o_gnt = o_any ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port among all icache/dcache ports; MEMARB_RR_EN selects rotating core priority.
// Grant registered one cycle after request; requesters hold wait high until their ACCESS cycle.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = NUM_CPUS,
    parameter int ADDR_W = WORD_W
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]  dstore,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  iload,
    output logic [CPUS-1:0][ADDR_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [ADDR_W-1:0]            ramstore,
    input  logic [ADDR_W-1:0]            ramload,
    input  logic [1:0]                   ramstate,
    output logic                         arb_busy
);
    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    r_state, w_state_nxt;
    logic [OW-1:0] r_owner_cpu, w_owner_cpu_nxt;
    logic          r_owner_is_d, w_owner_is_d_nxt;
    logic [OW-1:0] r_rr_ptr, w_rr_ptr_nxt;

    logic [CPUS-1:0] w_core_dreq;
    logic [CPUS-1:0] w_core_req;
    logic [OW-1:0]   w_start;
    logic [CPUS-1:0] w_pick_gnt;
    logic [OW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_own_req;
    ramstate_t       w_ramstate;

    assign w_ramstate  = ramstate_t'(ramstate);
    assign w_core_dreq = dREN | dWEN;
    assign w_core_req  = iREN | w_core_dreq;
    assign w_own_req   = r_owner_is_d ? w_core_dreq[r_owner_cpu] : iREN[r_owner_cpu];

`ifdef MEMARB_RR_EN
    assign w_start = (r_rr_ptr == OW'(CPUS - 1)) ? '0 : r_rr_ptr + OW'(1);
`else
    assign w_start = '0;
`endif

    rr_picker #(
        .N  (CPUS),
        .IW (OW)
    ) u_rr_picker (
        .i_req   (w_core_req),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_owner_cpu  <= '0;
            r_owner_is_d <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner_cpu  <= w_owner_cpu_nxt;
            r_owner_is_d <= w_owner_is_d_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_cpu_nxt  = r_owner_cpu;
        w_owner_is_d_nxt = r_owner_is_d;
        w_rr_ptr_nxt     = r_rr_ptr;
        iwait            = '1;
        dwait            = '1;
        iload            = '0;
        dload            = '0;
        ramREN           = 1'b0;
        ramWEN           = 1'b0;
        ramaddr          = '0;
        ramstore         = '0;
        arb_busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt      = GRANT;
                    w_owner_cpu_nxt  = w_pick_idx;
                    w_owner_is_d_nxt = |(w_pick_gnt & w_core_dreq);
                end
            end
            GRANT: begin
                arb_busy = 1'b1;
                // A withdrawn request releases the port without completing.
                if (!w_own_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (r_owner_is_d) begin
                        ramaddr  = daddr[r_owner_cpu];
                        ramstore = dstore[r_owner_cpu];
                        ramWEN   = dWEN[r_owner_cpu];
                        ramREN   = dREN[r_owner_cpu] & ~dWEN[r_owner_cpu];
                    end else begin
                        ramaddr  = iaddr[r_owner_cpu];
                        ramREN   = 1'b1;
                    end
                    if (w_ramstate == ACCESS) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = r_owner_cpu;
                        if (r_owner_is_d) begin
                            dwait[r_owner_cpu] = 1'b0;
                            dload[r_owner_cpu] = ramload;
                        end else begin
                            iwait[r_owner_cpu] = 1'b0;
                            iload[r_owner_cpu] = ramload;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed cycle table, reset corner, randomized run vs model.
// Honours MEMARB_RR_EN for the priority-dependent expectations.
module tb_memory_arbiter;
    localparam int CPUS = 2;
`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] IA0 = 32'h0000_0040, IA1 = 32'h0000_1040;
    localparam logic [31:0] DA0 = 32'h0000_0100, DA1 = 32'h0000_1100;
    localparam logic [31:0] DS0 = 32'hDEAD_BEEF, DS1 = 32'hCAFE_F00D;
    localparam logic [31:0] RL  = 32'h8C01_0004, Z = 32'h0;
    localparam logic [1:0]  F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

    logic CLK = 1'b0;
    logic nRST;
    logic [CPUS-1:0]        iREN, dREN, dWEN;
    logic [CPUS-1:0][31:0]  iaddr, daddr, dstore;
    logic [CPUS-1:0]        iwait, dwait;
    logic [CPUS-1:0][31:0]  iload, dload;
    logic                   ramREN, ramWEN, arb_busy;
    logic [31:0]            ramaddr, ramstore, ramload;
    logic [1:0]             ramstate;

    always #5 CLK = ~CLK;

    memory_arbiter #(.CPUS(CPUS), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_busy(arb_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  iren, dren, dwen, rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dwr,
                                input logic [1:0] rs, input logic ren, input logic wen,
                                input logic [31:0] a, input logic [31:0] s,
                                input logic [1:0] iw, input logic [1:0] dwt, input logic b);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dwr; v.rs = rs;
        v.ren = ren; v.wen = wen; v.addr = a; v.store = s;
        v.iw = iw; v.dw = dwt; v.busy = b;
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model state: port ownership and round-robin pointer
    bit  m_grant, n_grant;
    int  m_own, n_own, m_rr, n_rr;
    bit  m_d, n_d;
    logic                  e_ren, e_wen, e_busy;
    logic [31:0]           e_addr, e_store;
    logic [CPUS-1:0]       e_iw, e_dw;
    logic [CPUS-1:0][31:0] e_il, e_dl;

    task automatic model_eval();
        e_ren = 1'b0; e_wen = 1'b0; e_busy = 1'b0; e_addr = '0; e_store = '0;
        e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
        n_grant = m_grant; n_own = m_own; n_d = m_d; n_rr = m_rr;
        if (!m_grant) begin
            for (int k = 0; k < CPUS; k++) begin
                int c = RR ? (m_rr + 1 + k) % CPUS : k;
                if (!n_grant && (iREN[c] || dREN[c] || dWEN[c])) begin
                    n_grant = 1'b1; n_own = c; n_d = dREN[c] || dWEN[c];
                end
            end
        end else begin
            e_busy = 1'b1;
            if (m_d ? (dREN[m_own] || dWEN[m_own]) : iREN[m_own]) begin
                if (m_d) begin
                    e_addr = daddr[m_own]; e_store = dstore[m_own];
                    e_wen = dWEN[m_own]; e_ren = dREN[m_own] && !dWEN[m_own];
                end else begin
                    e_addr = iaddr[m_own]; e_ren = 1'b1;
                end
                if (ramstate == A) begin
                    if (m_d) begin e_dw[m_own] = 1'b0; e_dl[m_own] = ramload; end
                    else     begin e_iw[m_own] = 1'b0; e_il[m_own] = ramload; end
                    n_rr = m_own; n_grant = 1'b0;
                end
            end else begin
                n_grant = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; ramstate = F;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        logic [31:0] ra, rs_v;
        logic [1:0]  rdw;
        logic [CPUS-1:0][31:0] ei, ed;

        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; ramstate = F; ramload = RL;
        iaddr[0] = IA0; iaddr[1] = IA1; daddr[0] = DA0; daddr[1] = DA1;
        dstore[0] = DS0; dstore[1] = DS1;
        #2;
        chk("rst_iwait", 64'(iwait), 64'(2'b11));
        chk("rst_dwait", 64'(dwait), 64'(2'b11));
        chk("rst_ramen", 64'({ramREN, ramWEN}), 64'(0));
        chk("rst_addr",  64'(ramaddr), 64'(0));
        chk("rst_busy",  64'(arb_busy), 64'(0));
        chk("rst_load",  64'(iload | dload), 64'(0));
        do_reset();

        if (RR) begin ra = DA1; rs_v = DS1; rdw = 2'b01; end
        else    begin ra = DA0; rs_v = DS0; rdw = 2'b10; end

        // single icache read, RAM latency 2
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, B, 1, 0, IA0, Z, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, B, 1, 0, IA0, Z, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, A, 1, 0, IA0, Z, 2'b10, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        // data write beats instruction fetch on the same core
        tbl.push_back(mk(2'b01, 2'b00, 2'b01, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b01, A, 0, 1, DA0, DS0, 2'b11, 2'b10, 1));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, A, 1, 0, IA0, Z, 2'b10, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        // ERROR twice then ACCESS
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, E, 1, 0, DA0, DS0, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, E, 1, 0, DA0, DS0, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, A, 1, 0, DA0, DS0, 2'b11, 2'b10, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        // read and write together on core 1: write wins
        tbl.push_back(mk(2'b00, 2'b10, 2'b10, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b00, 2'b10, 2'b10, A, 0, 1, DA1, DS1, 2'b11, 2'b01, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        // abandoned fetch: drop beats ACCESS, no wait pulse
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, B, 1, 0, IA1, Z, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, A, 0, 0, Z, Z, 2'b11, 2'b11, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
        // both cores hold dREN: priority order depends on build
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, A, 1, 0, DA0, DS0, 2'b11, 2'b10, 1));
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, A, 1, 0, ra, rs_v, 2'b11, rdw, 1));
        end
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 0, 0, Z, Z, 2'b11, 2'b11, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK);
            #1;
            iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen; ramstate = tbl[i].rs;
            @(negedge CLK);
            for (int c = 0; c < CPUS; c++) begin
                ei[c] = tbl[i].iw[c] ? Z : RL;
                ed[c] = tbl[i].dw[c] ? Z : RL;
            end
            chk($sformatf("v%0d_ren", i),   64'(ramREN),   64'(tbl[i].ren));
            chk($sformatf("v%0d_wen", i),   64'(ramWEN),   64'(tbl[i].wen));
            chk($sformatf("v%0d_addr", i),  64'(ramaddr),  64'(tbl[i].addr));
            chk($sformatf("v%0d_store", i), 64'(ramstore), 64'(tbl[i].store));
            chk($sformatf("v%0d_iwait", i), 64'(iwait),    64'(tbl[i].iw));
            chk($sformatf("v%0d_dwait", i), 64'(dwait),    64'(tbl[i].dw));
            chk($sformatf("v%0d_busy", i),  64'(arb_busy), 64'(tbl[i].busy));
            chk($sformatf("v%0d_iload", i), 64'(iload),    64'(ei));
            chk($sformatf("v%0d_dload", i), 64'(dload),    64'(ed));
        end

        // asynchronous reset in the middle of a grant
        @(posedge CLK); #1; dREN = 2'b01; ramstate = B;
        @(negedge CLK);
        chk("mr_idle_ren", 64'(ramREN), 64'(0));
        @(posedge CLK); #1;
        chk("mr_grant_ren", 64'(ramREN), 64'(1));
        #2; nRST = 1'b0; #1;
        chk("mr_async_ren",  64'(ramREN), 64'(0));
        chk("mr_async_wait", 64'({iwait, dwait}), 64'(4'hF));
        chk("mr_async_busy", 64'(arb_busy), 64'(0));
        @(posedge CLK);
        @(negedge CLK); nRST = 1'b1; dREN = 2'b11; #1;
        chk("mr_post_busy", 64'(arb_busy), 64'(0));
        chk("mr_post_ren",  64'(ramREN), 64'(0));
        @(posedge CLK); #1;
        chk("mr_regrant_addr", 64'(ramaddr), 64'(RR ? DA1 : DA0));
        chk("mr_regrant_busy", 64'(arb_busy), 64'(1));

        // randomized run against the model
        do_reset();
        m_grant = 1'b0; m_own = 0; m_d = 1'b0; m_rr = 0;
        n_grant = 1'b0; n_own = 0; n_d = 1'b0; n_rr = 0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge CLK);
            m_grant = n_grant; m_own = n_own; m_d = n_d; m_rr = n_rr;
            #1;
            for (int c = 0; c < CPUS; c++) begin
                if ($urandom_range(5) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(5) == 0) dREN[c] = ~dREN[c];
                if ($urandom_range(7) == 0) dWEN[c] = ~dWEN[c];
                iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
            end
            ramstate = 2'($urandom_range(3));
            ramload  = $urandom;
            @(negedge CLK);
            model_eval();
            chk($sformatf("r%0d_ren", n),   64'(ramREN),   64'(e_ren));
            chk($sformatf("r%0d_wen", n),   64'(ramWEN),   64'(e_wen));
            chk($sformatf("r%0d_addr", n),  64'(ramaddr),  64'(e_addr));
            chk($sformatf("r%0d_store", n), 64'(ramstore), 64'(e_store));
            chk($sformatf("r%0d_busy", n),  64'(arb_busy), 64'(e_busy));
            chk($sformatf("r%0d_iwait", n), 64'(iwait),    64'(e_iw));
            chk($sformatf("r%0d_dwait", n), 64'(dwait),    64'(e_dw));
            chk($sformatf("r%0d_iload", n), 64'(iload),    64'(e_il));
            chk($sformatf("r%0d_dload", n), 64'(dload),    64'(e_dl));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
